mem_bist_master: RTL
====================

# mem_bist_master

Built-in self-test initiator for the single-port synchronous memory (registered read, 1-cycle latency, `we`/`addr`/`data_in`/`data_out` interface). On `start` it writes a selectable data pattern to every location, reads all locations back, compares them against the expected pattern and reports a pass/fail summary. It sits between the test/CSR logic and the memory port, and owns that port while `busy`.

## Interface
- `WIDTH`, 8: memory data width.
- `DEPTH`, 16: number of locations tested, 2 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- `ADDR_WIDTH`, 4: memory address width.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a test run; sampled only in IDLE.
- `abort`  in  1  cancel the run in progress; ignored in IDLE.
- `pattern_sel`  in  2  0 = all-zero, 1 = all-ones, 2 = checkerboard, 3 = address+seed.
- `seed`  in  WIDTH  pattern-3 offset; sampled with `start`.
- `busy`  out  1  a run is in progress (WRITE/READ/DRAIN).
- `done`  out  1  one-cycle pulse when a run completes normally.
- `pass`  out  1  last completed run had zero mismatches; held until next `start`.
- `err_count`  out  ADDR_WIDTH+1  mismatch count of the current/last run.
- `first_err_addr`  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  WIDTH  memory write data.
- `mem_rdata`  in  WIDTH  memory read data, valid the cycle after its address.

## Operation
- Reset values: all outputs 0, state IDLE.
- `pattern_sel` and `seed` are captured on the `start` edge and held for the run.
- Expected data exp(a): pattern 0 → all 0; 1 → all 1; 2 → 0x55-style alternating bits (bit i = ~i[0]) when a[0]=0, bitwise inverse when a[0]=1; 3 → (seed + a) mod 2^WIDTH, with a zero-extended or truncated to WIDTH.
- FSM states and transitions:
  - IDLE → WRITE on `start`.
  - WRITE: `mem_we`=1, `mem_addr`=a, `mem_wdata`=exp(a) for a = 0..DEPTH-1, one address per cycle; after a=DEPTH-1 → READ.
  - READ: `mem_we`=0, `mem_addr`=0..DEPTH-1, one per cycle; after DEPTH-1 → DRAIN.
  - DRAIN: one cycle to compare the final read word, then → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
- Compare pipeline: the issued read address is registered alongside a valid bit. In the following cycle `mem_rdata` is compared against exp(registered address). On mismatch, `err_count` increments, saturating at 2^(ADDR_WIDTH+1)-1. If it was the first mismatch, `first_err_addr` loads the registered address.
- `pass` updates in DONE to (`err_count`==0). `err_count`, `first_err_addr` and `pass` clear on the `start` edge.
- `abort` in any non-IDLE state → IDLE on the next edge:
  - `mem_we` drops in that same edge; no `done` pulse.
  - `pass` = 0; `err_count` and `first_err_addr` hold their partial values.
- `abort` and `start` together in IDLE: `start` wins, `abort` is ignored.
- `start` while not in IDLE is ignored.
- In IDLE, `mem_we`=0 and `mem_addr`/`mem_wdata` hold their last values.

## Timing
- Let E0 be the edge that samples `start`.
- Cycles 1..DEPTH after E0: writes to addresses 0..DEPTH-1.
- Cycles DEPTH+1..2·DEPTH: reads of addresses 0..DEPTH-1.
- Cycle 2·DEPTH+1: DRAIN. Cycle 2·DEPTH+2: `done`=1, `busy`=0, `pass` valid.
- `busy` is high exactly 2·DEPTH+1 cycles. A new `start` is accepted in cycle 2·DEPTH+3.
- The first read follows the last write by one cycle; the memory must return the newly written data (write commits on the edge before the read address is presented).
- `rst_n` asserted mid-run returns everything to reset values immediately; memory contents are not restored.

## Structure
- Package `mem_bist_pkg`: state enum (IDLE, WRITE, READ, DRAIN, DONE), pattern-select constants, and a function `bist_exp_data(pattern, seed, addr)` parameterised by WIDTH/ADDR_WIDTH.
- Single module; no sub-module required. The expected-data function is shared with the bench scoreboard.

## Test plan
- Bench setup: WIDTH=8, DEPTH=16, connected to the single-port memory model.
- Pattern 0, clean memory → `done` in cycle 34 after E0, `pass`=1, `err_count`=0, `first_err_addr`=0.
- Pattern 3, seed=0xF8 → memory holds 0xF8..0xFF, 0x00..0x07 (wraps); `pass`=1.
- Pattern 2, bench flips bit 0 of `mem_rdata` for addresses 5 and 9 → `err_count`=2, `first_err_addr`=5, `pass`=0.
- `abort` in cycle 20 after E0 → `mem_we`=0 and `busy`=0 next cycle, no `done`, `pass`=0; a following `start` runs cleanly to `pass`=1.
- `rst_n` low during READ → all outputs 0 immediately. `start` during `busy` → no effect on the sequence; `start`+`abort` in IDLE → run starts.

Source files
------------

// File: rtl/mem_bist_master_pkg.sv
// Shared types and expected-data function for the memory BIST initiator.
// Pure definitions, no timing.
// No flow control of its own.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } bist_state_t;

    localparam logic [1:0] PAT_ZERO      = 2'd0;
    localparam logic [1:0] PAT_ONES      = 2'd1;
    localparam logic [1:0] PAT_CHECKER   = 2'd2;
    localparam logic [1:0] PAT_ADDR_SEED = 2'd3;

    // Computed at 64 bits and masked to 'width'; callers truncate to their data width.
    function automatic logic [63:0] bist_exp_data(input logic [1:0]  pattern,
                                                  input logic [63:0] seed,
                                                  input logic [63:0] addr,
                                                  input int          width);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        r    = '0;
        case (pattern)
            PAT_ZERO:      r = '0;
            PAT_ONES:      r = '1;
            PAT_CHECKER:   r = addr[0] ? {32{2'b10}} : {32{2'b01}};
            PAT_ADDR_SEED: r = seed + addr;
            default:       r = '0;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/mem_bist_master_if.sv
// Single-port synchronous memory port (registered read, 1-cycle latency).
// Read data valid one cycle after its address.
// No backpressure: the memory accepts one access per cycle.
interface mem_bist_master_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;

    modport master (output mem_we, output mem_addr, output mem_wdata, input  mem_rdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_bist_master.sv
// Memory BIST initiator: write pattern to all locations, read back, count mismatches.
// Run takes 2*DEPTH+2 cycles from start to done; compare lags each read by one cycle.
// No backpressure; owns the memory port while busy, abort returns to IDLE next edge.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            pattern_sel,
    input  logic [WIDTH-1:0]      seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    mem_bist_master_if.master     mem
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = '1;
    localparam logic [ADDR_WIDTH:0]   ERR_ONE   = (ADDR_WIDTH+1)'(1);

    bist_state_t           state;
    logic [1:0]            pat_q;
    logic [WIDTH-1:0]      seed_q;
    logic                  cmp_vld;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic                  mismatch;
    logic [ADDR_WIDTH:0]   err_nxt;

    function automatic logic [WIDTH-1:0] exp_at(input logic [1:0]            p,
                                                input logic [WIDTH-1:0]      s,
                                                input logic [ADDR_WIDTH-1:0] a);
        return WIDTH'(bist_exp_data(p, 64'(s), 64'(a), WIDTH));
    endfunction

    // Compare the word returned for last cycle's read address; saturating error count.
    always_comb begin
        mismatch = cmp_vld && (mem.mem_rdata != exp_at(pat_q, seed_q, cmp_addr));
        err_nxt  = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_nxt = err_count + ERR_ONE;
        end
    end

    // Run sequencer with registered memory-port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pat_q          <= '0;
            seed_q         <= '0;
            cmp_vld        <= 1'b0;
            cmp_addr       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
        end else begin
            // Compare results land regardless of state; start/abort below may override.
            if (mismatch) begin
                err_count <= err_nxt;
                if (err_count == '0) begin
                    first_err_addr <= cmp_addr;
                end
            end

            if ((state != IDLE) && abort) begin
                state      <= IDLE;
                busy       <= 1'b0;
                done       <= 1'b0;
                pass       <= 1'b0;
                cmp_vld    <= 1'b0;
                mem.mem_we <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state          <= WRITE;
                            pat_q          <= pattern_sel;
                            seed_q         <= seed;
                            busy           <= 1'b1;
                            pass           <= 1'b0;
                            err_count      <= '0;
                            first_err_addr <= '0;
                            mem.mem_we     <= 1'b1;
                            mem.mem_addr   <= '0;
                            mem.mem_wdata  <= exp_at(pattern_sel, seed, '0);
                        end
                    end
                    WRITE: begin
                        if (mem.mem_addr == LAST_ADDR) begin
                            state        <= READ;
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= '0;
                        end else begin
                            mem.mem_addr  <= mem.mem_addr + ADDR_ONE;
                            mem.mem_wdata <= exp_at(pat_q, seed_q, mem.mem_addr + ADDR_ONE);
                        end
                    end
                    READ: begin
                        cmp_vld  <= 1'b1;
                        cmp_addr <= mem.mem_addr;
                        if (mem.mem_addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            mem.mem_addr <= mem.mem_addr + ADDR_ONE;
                        end
                    end
                    DRAIN: begin
                        cmp_vld <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_nxt == '0);
                        state   <= DONE;
                    end
                    DONE: begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
